// File: rtl/ost_command_initiator.sv
// STC register-access master: expands one timing request into write strobes
// (addr 1..7) or a read with bounded wait, then pulses a one-cycle completion.
module ost_command_initiator #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  iv_req_op,
    input  logic [63:0] iv_req_data,
    input  logic [31:0] iv_req_pit,
    input  logic [18:0] iv_req_addr,
    output logic        o_stc_wr,
    output logic [31:0] ov_stc_wdata,
    output logic [18:0] ov_stc_addr,
    output logic        o_stc_addr_fixed,
    output logic        o_stc_rd,
    input  logic        i_stc_wr,
    input  logic [31:0] iv_stc_rdata,
    input  logic [18:0] iv_stc_raddr,
    input  logic        i_stc_addr_fixed,
    output logic        o_rsp_valid,
    output logic [31:0] ov_rsp_data,
    output logic [18:0] ov_rsp_addr,
    output logic        o_rsp_timeout,
    output logic        o_rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_HI,
        S_WR_LO,
        S_WR_PIT,
        S_WR_ONE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] data_q, data_d;
    logic [31:0] pit_q, pit_d;
    logic [18:0] raddr_q, raddr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        timeout_q, timeout_d;
    logic        err_q, err_d;
    logic [18:0] last_addr_q, last_addr_d;

    logic        req_ready_q, req_ready_d;
    logic        stc_wr_q, stc_wr_d;
    logic        stc_rd_q, stc_rd_d;
    logic [31:0] stc_wdata_q, stc_wdata_d;
    logic [18:0] stc_addr_q, stc_addr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [18:0] rsp_addr_q, rsp_addr_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic        rsp_err_q, rsp_err_d;

    logic rd_match;
    assign rd_match = i_stc_wr && !i_stc_addr_fixed && (iv_stc_raddr == raddr_q);

    // Next-state and request latching.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        pit_d     = pit_q;
        raddr_d   = raddr_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (i_req_valid && req_ready_q) begin
                    op_d      = iv_req_op;
                    data_d    = iv_req_data;
                    pit_d     = iv_req_pit;
                    raddr_d   = iv_req_addr;
                    cnt_d     = '0;
                    rdata_d   = '0;
                    timeout_d = 1'b0;
                    err_d     = 1'b0;
                    case (iv_req_op)
                        3'd1:                   state_d = S_WR_HI;
                        3'd0, 3'd2, 3'd3, 3'd4: state_d = S_WR_ONE;
                        3'd5:                   state_d = S_RD_ISSUE;
                        default: begin
                            // Illegal ops spend the issue slot without a strobe,
                            // so they answer on the same cycle as a single write.
                            err_d   = 1'b1;
                            state_d = S_WR_ONE;
                        end
                    endcase
                end
            end
            S_WR_HI:    state_d = S_WR_LO;
            S_WR_LO:    state_d = S_WR_PIT;
            S_WR_PIT:   state_d = S_DONE;
            S_WR_ONE:   state_d = S_DONE;
            S_RD_ISSUE: begin
                cnt_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rd_match) begin
                    rdata_d = iv_stc_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 2)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the
    // same cycle the state is entered.
    always_comb begin
        stc_wr_d    = 1'b0;
        stc_rd_d    = 1'b0;
        stc_wdata_d = '0;
        stc_addr_d  = '0;

        case (state_d)
            S_WR_HI: begin
                stc_wr_d    = 1'b1;
                stc_addr_d  = 19'd2;
                stc_wdata_d = data_d[63:32];
            end
            S_WR_LO: begin
                stc_wr_d    = 1'b1;
                stc_addr_d  = 19'd3;
                stc_wdata_d = data_d[31:0];
            end
            S_WR_PIT: begin
                stc_wr_d    = 1'b1;
                stc_addr_d  = 19'd4;
                stc_wdata_d = pit_d;
            end
            S_WR_ONE: begin
                case (op_d)
                    3'd0: begin
                        stc_wr_d    = 1'b1;
                        stc_addr_d  = 19'd1;
                        stc_wdata_d = {20'b0, data_d[11:0]};
                    end
                    3'd2: begin
                        stc_wr_d    = 1'b1;
                        stc_addr_d  = 19'd5;
                        stc_wdata_d = data_d[31:0];
                    end
                    3'd3: begin
                        stc_wr_d    = 1'b1;
                        stc_addr_d  = 19'd6;
                        stc_wdata_d = data_d[31:0];
                    end
                    3'd4: begin
                        stc_wr_d    = 1'b1;
                        stc_addr_d  = 19'd7;
                        stc_wdata_d = data_d[31:0];
                    end
                    default: ;
                endcase
            end
            S_RD_ISSUE: begin
                stc_rd_d   = 1'b1;
                stc_addr_d = raddr_d;
            end
            default: ;
        endcase

        last_addr_d   = (stc_wr_d || stc_rd_d) ? stc_addr_d : last_addr_q;
        req_ready_d   = (state_d == S_IDLE);
        rsp_valid_d   = (state_d == S_DONE);
        rsp_data_d    = rsp_valid_d ? rdata_d     : '0;
        rsp_addr_d    = rsp_valid_d ? last_addr_d : '0;
        rsp_timeout_d = rsp_valid_d && timeout_d;
        rsp_err_d     = rsp_valid_d && err_d;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            data_q        <= '0;
            pit_q         <= '0;
            raddr_q       <= '0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            timeout_q     <= 1'b0;
            err_q         <= 1'b0;
            last_addr_q   <= '0;
            req_ready_q   <= 1'b1;
            stc_wr_q      <= 1'b0;
            stc_rd_q      <= 1'b0;
            stc_wdata_q   <= '0;
            stc_addr_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_addr_q    <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            data_q        <= data_d;
            pit_q         <= pit_d;
            raddr_q       <= raddr_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            timeout_q     <= timeout_d;
            err_q         <= err_d;
            last_addr_q   <= last_addr_d;
            req_ready_q   <= req_ready_d;
            stc_wr_q      <= stc_wr_d;
            stc_rd_q      <= stc_rd_d;
            stc_wdata_q   <= stc_wdata_d;
            stc_addr_q    <= stc_addr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign o_req_ready      = req_ready_q;
    assign o_stc_wr         = stc_wr_q;
    assign o_stc_rd         = stc_rd_q;
    assign ov_stc_wdata     = stc_wdata_q;
    assign ov_stc_addr      = stc_addr_q;
    assign o_stc_addr_fixed = 1'b0;
    assign o_rsp_valid      = rsp_valid_q;
    assign ov_rsp_data      = rsp_data_q;
    assign ov_rsp_addr      = rsp_addr_q;
    assign o_rsp_timeout    = rsp_timeout_q;
    assign o_rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_ost_command_initiator.sv
// Directed bench for ost_command_initiator: vector table for single-slot ops,
// hand-written sequences for set clock, reads, timeout and mid-sequence reset.
module tb_ost_command_initiator;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [2:0]  iv_req_op;
    logic [63:0] iv_req_data;
    logic [31:0] iv_req_pit;
    logic [18:0] iv_req_addr;
    logic        o_stc_wr;
    logic [31:0] ov_stc_wdata;
    logic [18:0] ov_stc_addr;
    logic        o_stc_addr_fixed;
    logic        o_stc_rd;
    logic        i_stc_wr;
    logic [31:0] iv_stc_rdata;
    logic [18:0] iv_stc_raddr;
    logic        i_stc_addr_fixed;
    logic        o_rsp_valid;
    logic [31:0] ov_rsp_data;
    logic [18:0] ov_rsp_addr;
    logic        o_rsp_timeout;
    logic        o_rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    ost_command_initiator #(.TIMEOUT_CYC(16), .CNT_W(8)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .iv_req_op        (iv_req_op),
        .iv_req_data      (iv_req_data),
        .iv_req_pit       (iv_req_pit),
        .iv_req_addr      (iv_req_addr),
        .o_stc_wr         (o_stc_wr),
        .ov_stc_wdata     (ov_stc_wdata),
        .ov_stc_addr      (ov_stc_addr),
        .o_stc_addr_fixed (o_stc_addr_fixed),
        .o_stc_rd         (o_stc_rd),
        .i_stc_wr         (i_stc_wr),
        .iv_stc_rdata     (iv_stc_rdata),
        .iv_stc_raddr     (iv_stc_raddr),
        .i_stc_addr_fixed (i_stc_addr_fixed),
        .o_rsp_valid      (o_rsp_valid),
        .ov_rsp_data      (ov_rsp_data),
        .ov_rsp_addr      (ov_rsp_addr),
        .o_rsp_timeout    (o_rsp_timeout),
        .o_rsp_err        (o_rsp_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to 1ns after the next rising edge; outputs are stable there.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present a request for one edge (edge T); returns in cycle T+1.
    task automatic issue(input logic [2:0] op, input logic [63:0] data,
                         input logic [31:0] pit, input logic [18:0] addr);
        i_req_valid = 1'b1;
        iv_req_op   = op;
        iv_req_data = data;
        iv_req_pit  = pit;
        iv_req_addr = addr;
        step();
        i_req_valid = 1'b0;
        iv_req_op   = '0;
        iv_req_data = '0;
        iv_req_pit  = '0;
        iv_req_addr = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " wr"},    64'(o_stc_wr),     64'h0);
        check({tag, " rd"},    64'(o_stc_rd),     64'h0);
        check({tag, " addr"},  64'(ov_stc_addr),  64'h0);
        check({tag, " wdata"}, 64'(ov_stc_wdata), 64'h0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [63:0] data;
        logic        exp_wr;
        logic [18:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [18:0] exp_rsp_addr;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{3'd3, 64'h0000_0000_0000_0100,    1'b1, 19'd6, 32'h0000_0100, 19'd6, 1'b0};
        vecs[1] = '{3'd0, 64'hFFFF_FFFF_FFFF_FABC,    1'b1, 19'd1, 32'h0000_0ABC, 19'd1, 1'b0};
        vecs[2] = '{3'd2, 64'hDEAD_BEEF_1234_5678,    1'b1, 19'd5, 32'h1234_5678, 19'd5, 1'b0};
        vecs[3] = '{3'd4, 64'h0000_0000_8000_0001,    1'b1, 19'd7, 32'h8000_0001, 19'd7, 1'b0};
        vecs[4] = '{3'd6, 64'h0000_0000_FFFF_FFFF,    1'b0, 19'd0, 32'h0000_0000, 19'd7, 1'b1};
        vecs[5] = '{3'd7, 64'h0000_0000_1111_1111,    1'b0, 19'd0, 32'h0000_0000, 19'd7, 1'b1};

        i_rst_n          = 1'b0;
        i_req_valid      = 1'b0;
        iv_req_op        = '0;
        iv_req_data      = '0;
        iv_req_pit       = '0;
        iv_req_addr      = '0;
        i_stc_wr         = 1'b0;
        iv_stc_rdata     = '0;
        iv_stc_raddr     = '0;
        i_stc_addr_fixed = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst ready", 64'(o_req_ready), 64'h1);
        check_quiet("rst");
        check("rst fixed", 64'(o_stc_addr_fixed), 64'h0);
        check("rst rsp_valid", 64'(o_rsp_valid), 64'h0);
        check("rst rsp_data", 64'(ov_rsp_data), 64'h0);
        check("rst rsp_flags", 64'({o_rsp_timeout, o_rsp_err}), 64'h0);
        i_rst_n = 1'b1;
        step();

        // Single-slot ops: strobe (or none) at T+1, completion at T+2, ready at T+3
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].op, vecs[i].data, 32'hCAFE_F00D, 19'h7_FFFF);
            check($sformatf("v%0d T+1 ready", i), 64'(o_req_ready), 64'h0);
            check($sformatf("v%0d T+1 wr", i), 64'(o_stc_wr), 64'(vecs[i].exp_wr));
            check($sformatf("v%0d T+1 rd", i), 64'(o_stc_rd), 64'h0);
            check($sformatf("v%0d T+1 addr", i), 64'(ov_stc_addr), 64'(vecs[i].exp_addr));
            check($sformatf("v%0d T+1 wdata", i), 64'(ov_stc_wdata), 64'(vecs[i].exp_wdata));
            check($sformatf("v%0d T+1 rsp_valid", i), 64'(o_rsp_valid), 64'h0);
            step();
            check($sformatf("v%0d T+2 rsp_valid", i), 64'(o_rsp_valid), 64'h1);
            check($sformatf("v%0d T+2 rsp_addr", i), 64'(ov_rsp_addr), 64'(vecs[i].exp_rsp_addr));
            check($sformatf("v%0d T+2 rsp_data", i), 64'(ov_rsp_data), 64'h0);
            check($sformatf("v%0d T+2 timeout", i), 64'(o_rsp_timeout), 64'h0);
            check($sformatf("v%0d T+2 err", i), 64'(o_rsp_err), 64'(vecs[i].exp_err));
            check($sformatf("v%0d T+2 wr", i), 64'(o_stc_wr), 64'h0);
            step();
            check($sformatf("v%0d T+3 rsp_valid", i), 64'(o_rsp_valid), 64'h0);
            check($sformatf("v%0d T+3 ready", i), 64'(o_req_ready), 64'h1);
        end

        // Set clock: three back-to-back writes, completion at T+4
        issue(3'd1, 64'h0000_0001_2345_6789, 32'h0000_0400, 19'd0);
        check("clk T+1 wr", 64'(o_stc_wr), 64'h1);
        check("clk T+1 addr", 64'(ov_stc_addr), 64'd2);
        check("clk T+1 wdata", 64'(ov_stc_wdata), 64'h1);
        check("clk T+1 ready", 64'(o_req_ready), 64'h0);
        step();
        check("clk T+2 wr", 64'(o_stc_wr), 64'h1);
        check("clk T+2 addr", 64'(ov_stc_addr), 64'd3);
        check("clk T+2 wdata", 64'(ov_stc_wdata), 64'h2345_6789);
        check("clk T+2 ready", 64'(o_req_ready), 64'h0);
        step();
        check("clk T+3 wr", 64'(o_stc_wr), 64'h1);
        check("clk T+3 addr", 64'(ov_stc_addr), 64'd4);
        check("clk T+3 wdata", 64'(ov_stc_wdata), 64'h400);
        check("clk T+3 rsp_valid", 64'(o_rsp_valid), 64'h0);
        step();
        check_quiet("clk T+4");
        check("clk T+4 rsp_valid", 64'(o_rsp_valid), 64'h1);
        check("clk T+4 rsp_addr", 64'(ov_rsp_addr), 64'd4);
        check("clk T+4 rsp_data", 64'(ov_rsp_data), 64'h0);
        check("clk T+4 ready", 64'(o_req_ready), 64'h0);
        step();
        check("clk T+5 ready", 64'(o_req_ready), 64'h1);
        check("clk T+5 rsp_valid", 64'(o_rsp_valid), 64'h0);

        // Nominal read: responder answers the cycle after the read strobe
        issue(3'd5, 64'h0, 32'h0, 19'd0);
        check("rd T+1 rd", 64'(o_stc_rd), 64'h1);
        check("rd T+1 wr", 64'(o_stc_wr), 64'h0);
        check("rd T+1 addr", 64'(ov_stc_addr), 64'd0);
        step();
        check("rd T+2 rd", 64'(o_stc_rd), 64'h0);
        i_stc_wr     = 1'b1;
        iv_stc_raddr = 19'd0;
        iv_stc_rdata = 32'h8000_3434;
        step();
        i_stc_wr     = 1'b0;
        iv_stc_rdata = '0;
        check("rd T+3 rsp_valid", 64'(o_rsp_valid), 64'h1);
        check("rd T+3 rsp_data", 64'(ov_rsp_data), 64'h8000_3434);
        check("rd T+3 rsp_addr", 64'(ov_rsp_addr), 64'd0);
        check("rd T+3 flags", 64'({o_rsp_timeout, o_rsp_err}), 64'h0);
        step();
        check("rd T+4 ready", 64'(o_req_ready), 64'h1);

        // Silent responder: timeout 16 cycles after the read strobe (T+1 -> T+17);
        // a stray address and a fixed-address response must both be ignored
        issue(3'd5, 64'h0, 32'h0, 19'd7);
        check("to T+1 rd", 64'(o_stc_rd), 64'h1);
        check("to T+1 addr", 64'(ov_stc_addr), 64'd7);
        for (int k = 2; k <= 16; k++) begin
            step();
            i_stc_wr         = (k == 4) || (k == 6);
            iv_stc_raddr     = (k == 4) ? 19'd3 : 19'd7;
            i_stc_addr_fixed = (k == 6);
            iv_stc_rdata     = 32'hBAD0_0000 | 32'(k);
            check($sformatf("to T+%0d rsp_valid", k), 64'(o_rsp_valid), 64'h0);
        end
        step();
        i_stc_wr         = 1'b0;
        i_stc_addr_fixed = 1'b0;
        iv_stc_raddr     = '0;
        iv_stc_rdata     = '0;
        check("to T+17 rsp_valid", 64'(o_rsp_valid), 64'h1);
        check("to T+17 timeout", 64'(o_rsp_timeout), 64'h1);
        check("to T+17 rsp_data", 64'(ov_rsp_data), 64'h0);
        check("to T+17 rsp_addr", 64'(ov_rsp_addr), 64'd7);
        check("to T+17 err", 64'(o_rsp_err), 64'h0);
        step();
        check("to T+18 ready", 64'(o_req_ready), 64'h1);

        // Match in the final wait cycle wins over the timeout
        issue(3'd5, 64'h0, 32'h0, 19'd9);
        for (int k = 2; k <= 16; k++) begin
            step();
            i_stc_wr     = (k == 16);
            iv_stc_raddr = 19'd9;
            iv_stc_rdata = 32'h0A0B_0C0D;
        end
        step();
        i_stc_wr     = 1'b0;
        iv_stc_raddr = '0;
        iv_stc_rdata = '0;
        check("late T+17 rsp_valid", 64'(o_rsp_valid), 64'h1);
        check("late T+17 timeout", 64'(o_rsp_timeout), 64'h0);
        check("late T+17 rsp_data", 64'(ov_rsp_data), 64'h0A0B_0C0D);
        step();

        // Reset asserted during WR_LO of a set-clock command
        issue(3'd1, 64'h0000_00AA_0000_00BB, 32'h0000_0CCC, 19'd0);
        check("abort T+1 addr", 64'(ov_stc_addr), 64'd2);
        step();
        check("abort T+2 addr", 64'(ov_stc_addr), 64'd3);
        i_rst_n = 1'b0;
        #1;
        check_quiet("abort rst");
        check("abort rst ready", 64'(o_req_ready), 64'h1);
        check("abort rst rsp_valid", 64'(o_rsp_valid), 64'h0);
        step();
        check("abort hold wr", 64'(o_stc_wr), 64'h0);
        i_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("abort post%0d wr", k), 64'(o_stc_wr), 64'h0);
            check($sformatf("abort post%0d rsp_valid", k), 64'(o_rsp_valid), 64'h0);
        end
        check("abort post ready", 64'(o_req_ready), 64'h1);
        issue(3'd0, 64'h0000_0000_0000_F5A5, 32'h0, 19'd0);
        check("after T+1 wr", 64'(o_stc_wr), 64'h1);
        check("after T+1 addr", 64'(ov_stc_addr), 64'd1);
        check("after T+1 wdata", 64'(ov_stc_wdata), 64'h5A5);
        step();
        check("after T+2 rsp_valid", 64'(o_rsp_valid), 64'h1);
        check("after T+2 rsp_addr", 64'(ov_rsp_addr), 64'd1);
        check("after T+2 err", 64'(o_rsp_err), 64'h0);
        step();
        check("after T+3 ready", 64'(o_req_ready), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
